hi_fsk_reader_ctrl: RTL

Sequencer for the HF FSK reader datapath (ISO15693 two-subcarrier receive). It accepts a receive command from the ARM-side configuration logic and powers the carrier. It waits for the field to settle, then arms the FSK edge-period datapath and watches its edge periods for a start-of-frame run. It then gates the SSP byte stream for a bounded capture and reports done, timeout or early end-of-frame.

---
 rtl/hi_fsk_reader_ctrl_pkg.sv | 33 +++
 rtl/hi_fsk_reader_ctrl_band_detect.sv | 51 +++++
 rtl/hi_fsk_reader_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hi_fsk_reader_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hi_fsk_reader_ctrl_pkg : shared state encoding, frequency codes, band limits
// Rev 1.0
// ---------------------------------------------------------------------------
package hi_fsk_reader_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LISTEN  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4
  } state_e;

  localparam logic [1:0] FPGA_HF_FSK_READER_OUTPUT_1695_KHZ = 2'd0;
  localparam logic [1:0] FPGA_HF_FSK_READER_OUTPUT_848_KHZ  = 2'd1;
  localparam logic [1:0] FPGA_HF_FSK_READER_OUTPUT_424_KHZ  = 2'd2;
  localparam logic [1:0] FPGA_HF_FSK_READER_OUTPUT_212_KHZ  = 2'd3;

  localparam int unsigned C_BAND_LO_DEFAULT = 26;
  localparam int unsigned C_BAND_HI_DEFAULT = 34;
  localparam int unsigned C_SOF_RUN_DEFAULT = 4;

  // A zero period means the datapath saw no edge, so it never counts as in-band.
  function automatic logic period_in_band(input logic [7:0] p,
                                          input int unsigned lo,
                                          input int unsigned hi);
    return (p != 8'd0) && ({24'd0, p} >= lo) && ({24'd0, p} <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hi_fsk_reader_ctrl_band_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hi_fsk_band_detect : in-band period compare and saturating start-of-frame run
// Rev 1.0
// ---------------------------------------------------------------------------
module hi_fsk_band_detect
  import hi_fsk_reader_ctrl_pkg::*;
#(
  parameter int unsigned BAND_LO = C_BAND_LO_DEFAULT,
  parameter int unsigned BAND_HI = C_BAND_HI_DEFAULT,
  parameter int unsigned SOF_RUN = C_SOF_RUN_DEFAULT
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       clear,
  input  logic       period_valid,
  input  logic [7:0] period,
  output logic       in_band,
  output logic       sof_hit
);

  localparam logic [2:0] RUN_MAX = 3'(SOF_RUN);

  logic [2:0] run_q, run_d;

  always_comb begin
    in_band = period_in_band(period, BAND_LO, BAND_HI);
    run_d   = run_q;
    if (clear) begin
      run_d = 3'd0;
    end else if (period_valid) begin
      if (!in_band) begin
        run_d = 3'd0;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 3'd1;
      end
    end
    // Fires on the strobe that completes the run, so the sequencer moves that same edge.
    sof_hit = !clear && period_valid && in_band && (run_d == RUN_MAX);
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      run_q <= 3'd0;
    end else begin
      run_q <= run_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hi_fsk_reader_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hi_fsk_reader_ctrl : HF FSK reader sequencer (settle, SOF hunt, bounded capture)
// Rev 1.0
// ---------------------------------------------------------------------------
module hi_fsk_reader_ctrl
  import hi_fsk_reader_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 1356,
  parameter int unsigned LISTEN_TIMEOUT = 40000,
  parameter int unsigned SOF_RUN        = C_SOF_RUN_DEFAULT,
  parameter int unsigned BAND_LO        = C_BAND_LO_DEFAULT,
  parameter int unsigned BAND_HI        = C_BAND_HI_DEFAULT,
  parameter int unsigned EOF_GAP        = 512,
  parameter int unsigned MAX_BYTES      = 64
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_freq,
  input  logic       cmd_abort,
  input  logic       period_valid,
  input  logic [7:0] period,
  input  logic       ssp_frame,
  output logic       carrier_on,
  output logic       fsk_enable,
  output logic [1:0] output_frequency,
  output logic       capture_gate,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic [7:0] byte_count
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LISTEN_LAST = 16'(LISTEN_TIMEOUT - 1);
  localparam logic [9:0]  GAP_LAST    = 10'(EOF_GAP - 1);
  localparam logic [7:0]  BYTE_LIMIT  = 8'(MAX_BYTES);

  state_e     state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [9:0]  gap_q, gap_d;
  logic [7:0]  bytes_q, bytes_d, bytes_next;
  logic [1:0]  freq_q, freq_d;
  logic        carrier_q, carrier_d;
  logic        fsk_q, fsk_d;
  logic        gate_q, gate_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;

  logic in_band, sof_hit;

  hi_fsk_band_detect #(
    .BAND_LO (BAND_LO),
    .BAND_HI (BAND_HI),
    .SOF_RUN (SOF_RUN)
  ) u_band (
    .ck_1356meg   (ck_1356meg),
    .reset        (reset),
    .clear        (state_q != ST_LISTEN),
    .period_valid (period_valid),
    .period       (period),
    .in_band      (in_band),
    .sof_hit      (sof_hit)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    gap_d      = gap_q;
    bytes_d    = bytes_q;
    freq_d     = freq_q;
    timeout_d  = 1'b0;
    bytes_next = bytes_q + {7'd0, ssp_frame};

    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            freq_d  = cmd_freq;
            bytes_d = 8'd0;
            timer_d = 16'd0;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer_q == SETTLE_LAST) begin
            timer_d = 16'd0;
            state_d = ST_LISTEN;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        ST_LISTEN: begin
          // Start-of-frame is checked first so it beats a coincident timeout.
          if (sof_hit) begin
            gap_d   = 10'd0;
            state_d = ST_CAPTURE;
          end else if (timer_q == LISTEN_LAST) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        ST_CAPTURE: begin
          bytes_d = bytes_next;
          gap_d   = (period_valid && in_band) ? 10'd0 : gap_q + 10'd1;
          if ((bytes_next == BYTE_LIMIT) || (gap_q == GAP_LAST)) begin
            state_d = ST_FINISH;
          end
        end
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    carrier_d = (state_d == ST_SETTLE) || (state_d == ST_LISTEN) || (state_d == ST_CAPTURE);
    fsk_d     = (state_d == ST_LISTEN) || (state_d == ST_CAPTURE);
    gate_d    = (state_d == ST_CAPTURE);
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_FINISH);
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= 16'd0;
      gap_q     <= 10'd0;
      bytes_q   <= 8'd0;
      freq_q    <= 2'b00;
      carrier_q <= 1'b0;
      fsk_q     <= 1'b0;
      gate_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      bytes_q   <= bytes_d;
      freq_q    <= freq_d;
      carrier_q <= carrier_d;
      fsk_q     <= fsk_d;
      gate_q    <= gate_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign cmd_ready        = ready_q;
  assign carrier_on       = carrier_q;
  assign fsk_enable       = fsk_q;
  assign output_frequency = freq_q;
  assign capture_gate     = gate_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign timeout          = timeout_q;
  assign byte_count       = bytes_q;

endmodule
`default_nettype wire
